// File: rtl/sram64x8_dual_port_arbiter_if.sv
// Requester-side bundle for sram64x8_dual_port_arbiter: one valid/ready request
// channel and one fixed-latency read-response channel per requester.
interface sram64x8_dual_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_bmask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_bmask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_bmask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram64x8_dual_port_arbiter.sv
// Two-requester arbiter/sequencer in front of a 64x8 single-port SRAM macro.
// Define SRAM_CLEAR_EN to zero all 64 words after reset before accepting requests.
module sram64x8_dual_port_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  sram64x8_dual_port_arbiter_if.slave p0,
  sram64x8_dual_port_arbiter_if.slave p1,
  output logic                     sram_cen,
  output logic                     sram_gwen,
  output logic [DATA_W-1:0]        sram_wen,
  output logic [ADDR_W-1:0]        sram_a,
  output logic [DATA_W-1:0]        sram_d,
  input  logic [DATA_W-1:0]        sram_q,
  output logic                     init_done
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

`ifdef SRAM_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t state_reg, state_next;

  logic [1:0]        req_valid, req_we, gnt;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [DATA_W-1:0] req_bmask [2];
  logic              run, clearing, accept, sel, last1_reg;
  logic [ADDR_W-1:0] clr_addr;

  logic              cen_reg, gwen_reg;
  logic [DATA_W-1:0] wen_reg, d_reg;
  logic [ADDR_W-1:0] a_reg;
  logic              tag1_v_reg, tag1_p_reg, tag2_v_reg, tag2_p_reg;

  assign req_valid    = {p1.req_valid, p0.req_valid};
  assign req_we       = {p1.req_we, p0.req_we};
  assign req_addr[0]  = p0.req_addr;
  assign req_addr[1]  = p1.req_addr;
  assign req_wdata[0] = p0.req_wdata;
  assign req_wdata[1] = p1.req_wdata;
  assign req_bmask[0] = p0.req_bmask;
  assign req_bmask[1] = p1.req_bmask;

`ifdef SRAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
  assign clr_addr = clr_addr_reg;

  always_ff @(posedge clk) begin
    if (rst) clr_addr_reg <= '0;
    else     clr_addr_reg <= clr_addr_next;
  end
`else
  assign clr_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= RESET_STATE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    gnt        = '0;
    run        = (state_reg == ST_RUN);
    clearing   = (state_reg == ST_CLEAR);
`ifdef SRAM_CLEAR_EN
    clr_addr_next = clr_addr_reg;
    if (clearing) begin
      clr_addr_next = clr_addr_reg + 1'b1;
      if (clr_addr_reg == '1) state_next = ST_RUN;
    end
`endif
    // last1_reg=1 means port 1 was granted last, so port 0 wins a round-robin tie
    if (run) begin
      gnt[0] = req_valid[0] & (~req_valid[1] | (PRIO_MODE != 0) | last1_reg);
      gnt[1] = req_valid[1] & ~gnt[0];
    end
  end

  assign accept       = |gnt;
  assign sel          = gnt[1];
  assign p0.req_ready = gnt[0];
  assign p1.req_ready = gnt[1];
  assign init_done    = run;

  always_ff @(posedge clk) begin
    if (rst)         last1_reg <= 1'b1;
    else if (accept) last1_reg <= sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cen_reg  <= 1'b1;
      gwen_reg <= 1'b1;
      wen_reg  <= '1;
      a_reg    <= '0;
      d_reg    <= '0;
    end else if (clearing) begin
      cen_reg  <= 1'b0;
      gwen_reg <= 1'b0;
      wen_reg  <= '0;
      a_reg    <= clr_addr;
      d_reg    <= '0;
    end else if (accept) begin
      cen_reg <= 1'b0;
      a_reg   <= req_addr[sel];
      if (req_we[sel]) begin
        gwen_reg <= 1'b0;
        wen_reg  <= ~req_bmask[sel];
        d_reg    <= req_wdata[sel];
      end else begin
        gwen_reg <= 1'b1;
        wen_reg  <= '1;
      end
    end else begin
      // idle: A and D keep their last values to avoid needless toggling at the macro
      cen_reg  <= 1'b1;
      gwen_reg <= 1'b1;
      wen_reg  <= '1;
    end
  end

  assign sram_cen  = cen_reg;
  assign sram_gwen = gwen_reg;
  assign sram_wen  = wen_reg;
  assign sram_a    = a_reg;
  assign sram_d    = d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag1_v_reg <= 1'b0;
      tag1_p_reg <= 1'b0;
      tag2_v_reg <= 1'b0;
      tag2_p_reg <= 1'b0;
    end else begin
      tag1_v_reg <= accept & ~req_we[sel];
      tag1_p_reg <= sel;
      tag2_v_reg <= tag1_v_reg;
      tag2_p_reg <= tag1_p_reg;
    end
  end

  // Q is valid after the macro edge, so the second tag stage lines up with it
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      logic              valid_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          rdata_reg <= '0;
        end else begin
          valid_reg <= tag2_v_reg && (tag2_p_reg == 1'(gi));
          if (tag2_v_reg && (tag2_p_reg == 1'(gi))) rdata_reg <= sram_q;
        end
      end
    end
  endgenerate

  assign p0.rsp_valid = g_rsp[0].valid_reg;
  assign p0.rsp_rdata = g_rsp[0].rdata_reg;
  assign p1.rsp_valid = g_rsp[1].valid_reg;
  assign p1.rsp_rdata = g_rsp[1].rdata_reg;

endmodule

// File: tb/tb_sram64x8_dual_port_arbiter.sv
// Bench for sram64x8_dual_port_arbiter: macro model, array-based reference of memory
// contents and grant rules, directed cases plus randomized two-port traffic.
module tb_sram64x8_dual_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;
`ifdef SRAM_CLEAR_EN
  localparam int CLR = 64;
`else
  localparam int CLR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram64x8_dual_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0 ();
  sram64x8_dual_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1 ();
  sram64x8_dual_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) q0 ();
  sram64x8_dual_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) q1 ();

  logic          cen, gwen, init_done;
  logic [DW-1:0] wen, d, sram_q;
  logic [AW-1:0] a;
  logic          cen_b, gwen_b, init_b;
  logic [DW-1:0] wen_b, d_b;
  logic [AW-1:0] a_b;

  sram64x8_dual_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst), .p0(p0), .p1(p1),
    .sram_cen(cen), .sram_gwen(gwen), .sram_wen(wen), .sram_a(a), .sram_d(d),
    .sram_q(sram_q), .init_done(init_done)
  );

  // fixed-priority instance sees the same requests; only its grants are checked
  sram64x8_dual_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_prio (
    .clk(clk), .rst(rst), .p0(q0), .p1(q1),
    .sram_cen(cen_b), .sram_gwen(gwen_b), .sram_wen(wen_b), .sram_a(a_b), .sram_d(d_b),
    .sram_q(8'h00), .init_done(init_b)
  );

  assign q0.req_valid = p0.req_valid;
  assign q0.req_we    = p0.req_we;
  assign q0.req_addr  = p0.req_addr;
  assign q0.req_wdata = p0.req_wdata;
  assign q0.req_bmask = p0.req_bmask;
  assign q1.req_valid = p1.req_valid;
  assign q1.req_we    = p1.req_we;
  assign q1.req_addr  = p1.req_addr;
  assign q1.req_wdata = p1.req_wdata;
  assign q1.req_bmask = p1.req_bmask;

  function automatic logic [7:0] seed(input int i);
    return 8'(i * 29 + 11);
  endfunction

  // macro model: power-up contents are seed(addr)
  logic [DW-1:0] mem [64];
  logic mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed(i);
      mem_ready <= 1'b1;
    end else if (cen === 1'b0) begin
      if (gwen === 1'b0) mem[a] <= (mem[a] & wen) | (d & ~wen);
      else               sram_q <= mem[a];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model state
  logic [7:0] ref_mem [64];
  int         cyc = 0;
  bit         started = 0;
  bit         last1;
  int         clear_left;
  int         init_low_cnt;
  logic       exp_cen, exp_gwen;
  logic [7:0] exp_wen, exp_d;
  logic [5:0] exp_a;
  bit         slot_v [4];
  bit         slot_p [4];
  logic [7:0] slot_d [4];
  logic [7:0] exp_rd [2];
  bit         hs_flag [2];
  int         dut_rsp_cnt [2];
  logic [7:0] dut_last_rsp [2];
  int         prio_acc [2];

  task automatic model_step();
    bit due_v [2];
    bit v0, v1, g0, g1, pp;
    logic [5:0] ad;
    logic [7:0] wd, bm;
    int s;
    due_v = '{0, 0};
    s = cyc % 4;
    if (slot_v[s]) begin
      due_v[slot_p[s]] = 1;
      exp_rd[slot_p[s]] = slot_d[s];
    end
    slot_v[s] = 0;
    hs_flag = '{0, 0};
    if (started) begin
      check("sram_cen", cen, exp_cen);
      check("sram_gwen", gwen, exp_gwen);
      check("sram_wen", wen, exp_wen);
      check("sram_a", a, exp_a);
      check("sram_d", d, exp_d);
      check("rsp0_valid", p0.rsp_valid, due_v[0]);
      check("rsp1_valid", p1.rsp_valid, due_v[1]);
      check("rsp0_rdata", p0.rsp_rdata, exp_rd[0]);
      check("rsp1_rdata", p1.rsp_rdata, exp_rd[1]);
    end
    if (p0.rsp_valid === 1'b1) begin dut_rsp_cnt[0]++; dut_last_rsp[0] = p0.rsp_rdata; end
    if (p1.rsp_valid === 1'b1) begin dut_rsp_cnt[1]++; dut_last_rsp[1] = p1.rsp_rdata; end
    if (rst) begin
      if (!started) for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
      exp_cen = 1; exp_gwen = 1; exp_wen = 8'hFF; exp_a = '0; exp_d = '0;
      slot_v = '{0, 0, 0, 0};
      exp_rd = '{8'h00, 8'h00};
      last1 = 1;
      clear_left = CLR;
      init_low_cnt = 0;
      started = 1;
    end else if (started) begin
      if (init_done !== 1'b1) init_low_cnt++;
      check("init_done", init_done, clear_left == 0);
      exp_cen = 1; exp_gwen = 1; exp_wen = 8'hFF;
      if (clear_left > 0) begin
        check("ready0_clear", p0.req_ready, 0);
        check("ready1_clear", p1.req_ready, 0);
        exp_cen = 0; exp_gwen = 0; exp_wen = 8'h00; exp_d = 8'h00;
        exp_a = 6'(64 - clear_left);
        ref_mem[64 - clear_left] = 8'h00;
        clear_left--;
      end else begin
        v0 = p0.req_valid; v1 = p1.req_valid;
        if (v0 && v1) begin g0 = last1; g1 = !last1; end
        else begin g0 = v0; g1 = v1; end
        check("ready0", p0.req_ready, g0);
        check("ready1", p1.req_ready, g1);
        check("prio_ready0", q0.req_ready, v0);
        check("prio_ready1", q1.req_ready, v1 && !v0);
        if (v0) prio_acc[0]++;
        else if (v1) prio_acc[1]++;
        if (g0 || g1) begin
          pp = g1;
          hs_flag[pp] = 1;
          last1 = g1;
          ad = pp ? p1.req_addr : p0.req_addr;
          wd = pp ? p1.req_wdata : p0.req_wdata;
          bm = pp ? p1.req_bmask : p0.req_bmask;
          exp_cen = 0;
          exp_a = ad;
          if (pp ? p1.req_we : p0.req_we) begin
            exp_gwen = 0; exp_wen = ~bm; exp_d = wd;
            ref_mem[ad] = (ref_mem[ad] & ~bm) | (wd & bm);
          end else begin
            slot_v[(cyc + 3) % 4] = 1;
            slot_p[(cyc + 3) % 4] = pp;
            slot_d[(cyc + 3) % 4] = ref_mem[ad];
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0.req_valid = 0; p0.req_we = 0; p0.req_addr = '0; p0.req_wdata = '0; p0.req_bmask = '0;
    p1.req_valid = 0; p1.req_we = 0; p1.req_addr = '0; p1.req_wdata = '0; p1.req_bmask = '0;
  endtask

  task automatic set_port(input int port, input bit v, input bit we, input logic [5:0] ad,
                          input logic [7:0] wd, input logic [7:0] bm);
    if (port == 0) begin
      p0.req_valid = v; p0.req_we = we; p0.req_addr = ad; p0.req_wdata = wd; p0.req_bmask = bm;
    end else begin
      p1.req_valid = v; p1.req_we = we; p1.req_addr = ad; p1.req_wdata = wd; p1.req_bmask = bm;
    end
  endtask

  task automatic req(input int port, input bit we, input logic [5:0] ad,
                     input logic [7:0] wd, input logic [7:0] bm);
    int n;
    n = 0;
    set_port(port, 1, we, ad, wd, bm);
    do begin
      tick();
      n++;
    end while (!hs_flag[port] && n < 20);
    check("req_accepted", hs_flag[port], 1);
    set_port(port, 0, 0, ad, wd, bm);
  endtask

  task automatic wait_rsp(input int port, output int lat);
    int start;
    start = dut_rsp_cnt[port];
    lat = 0;
    while (dut_rsp_cnt[port] == start && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("init_done_up", init_done, 1);
  endtask

  initial begin
    int lat, c0, c1, pa0, pa1, bad;
    bit rec0 [8];
    bit rec1 [8];
    prio_acc = '{0, 0};
    dut_rsp_cnt = '{0, 0};
    idle();
    tick();
    tick();
    check("rst_cen", cen, 1);
    check("rst_gwen", gwen, 1);
    check("rst_wen", wen, 8'hFF);
    check("rst_rsp0_valid", p0.rsp_valid, 0);
    check("rst_rsp1_valid", p1.rsp_valid, 0);
    rst = 0;
    wait_init();
    check("init_low_cycles", init_low_cnt, CLR);

    // single port write then read
    c1 = dut_rsp_cnt[1];
    req(0, 1, 6'h2A, 8'hA5, 8'hFF);
    req(0, 0, 6'h2A, 8'h00, 8'h00);
    wait_rsp(0, lat);
    check("read_latency", lat, 3);
    check("rd_2a", dut_last_rsp[0], 8'hA5);
    check("rsp1_silent", dut_rsp_cnt[1], c1);

    // bit mask
    req(0, 1, 6'h05, 8'hFF, 8'hFF);
    req(0, 1, 6'h05, 8'h00, 8'h0F);
    req(0, 0, 6'h05, 8'h00, 8'h00);
    wait_rsp(0, lat);
    check("rd_mask", dut_last_rsp[0], 8'hF0);

    // contention: round robin on main instance, fixed priority on the other
    c0 = dut_rsp_cnt[0]; c1 = dut_rsp_cnt[1];
    pa0 = prio_acc[0]; pa1 = prio_acc[1];
    set_port(0, 1, 0, 6'h01, 8'h00, 8'h00);
    set_port(1, 1, 0, 6'h02, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick();
      rec0[i] = hs_flag[0];
      rec1[i] = hs_flag[1];
    end
    idle();
    repeat (4) tick();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rec0[i] == rec1[i]) bad++;
      if (i > 0 && rec0[i] == rec0[i-1]) bad++;
    end
    check("rr_alternate_errors", bad, 0);
    check("rr_rsp0_count", dut_rsp_cnt[0] - c0, 4);
    check("rr_rsp1_count", dut_rsp_cnt[1] - c1, 4);
    check("rr_rsp0_data", dut_last_rsp[0], ref_mem[1]);
    check("rr_rsp1_data", dut_last_rsp[1], ref_mem[2]);
    check("prio_p0_accepts", prio_acc[0] - pa0, 8);
    check("prio_p1_accepts", prio_acc[1] - pa1, 0);

    // randomized traffic, addresses biased low to collide often
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        set_port(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63)),
                 8'($urandom), 8'($urandom));
      tick();
    end
    idle();
    repeat (4) tick();

    // reset one cycle after a read handshake drops the response
    c0 = dut_rsp_cnt[0]; c1 = dut_rsp_cnt[1];
    req(0, 0, 6'h10, 8'h00, 8'h00);
    rst = 1;
    tick();
    tick();
    rst = 0;
    repeat (6) tick();
    check("midrst_rsp0", dut_rsp_cnt[0], c0);
    check("midrst_rsp1", dut_rsp_cnt[1], c1);
    wait_init();
    check("init_low_cycles_2", init_low_cnt, CLR);
`ifdef SRAM_CLEAR_EN
    req(1, 0, 6'h3F, 8'h00, 8'h00);
    wait_rsp(1, lat);
    check("rd_3f_cleared", dut_last_rsp[1], 8'h00);
`endif
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
